// File: rtl/cpu_pkg.sv
// Shared LEGv8 pipeline definitions: register index type, XZR index and
// hazard-control FSM states.
package cpu_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t XZR_IDX = 5'd31;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } hcu_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value; clear has priority over enable.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing for the 5-stage LEGv8 core: load-use bubbles, branch
// flushes, data-memory freezes, stall statistics and a sticky memory timeout.
module hazard_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WAIT_LIMIT = 64,
  parameter reg_idx_t    XZR_IDX    = cpu_pkg::XZR_IDX
) (
  input  logic             clk,
  input  logic             reset,
  input  reg_idx_t         ifid_rs1,
  input  reg_idx_t         ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  reg_idx_t         idex_rd,
  input  logic             idex_memread,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             stage_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);

  hcu_state_t       state_q, state_d;
  logic             timeout_q, timeout_d;
  logic [WaitW-1:0] wait_cnt;
  logic             load_use;
  logic             mem_stall;
  logic             wait_en, wait_clr, stall_en;
  logic             at_limit;

  assign load_use = idex_memread && (idex_rd != XZR_IDX) &&
                    ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
  assign mem_stall = dmem_req && !dmem_ready;

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    stage_en    = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    unique case (state_q)
      INIT: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      RUN: begin
        if (mem_stall) begin
          // Freeze: every enable low, nothing flushed or bubbled.
        end else if (branch_taken) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          stage_en    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          stage_en    = 1'b1;
          idex_bubble = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          stage_en   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:     state_d = RUN;
      RUN:      if (mem_stall) state_d = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_d = RUN;
      default:  state_d = INIT;
    endcase
  end

  // Counter is zero on entry to MEM_WAIT, so the first increment yields 1.
  assign wait_en  = ((state_q == RUN) && mem_stall) || ((state_q == MEM_WAIT) && !dmem_ready);
  assign wait_clr = (state_q == MEM_WAIT) && dmem_ready;
  assign stall_en = (state_q != INIT) && !pc_write;

  assign at_limit    = (wait_cnt == WaitW'(WAIT_LIMIT));
  assign timeout_d   = timeout_q || at_limit;
  assign mem_timeout = timeout_q || at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .Width (WaitW)
  ) u_wait_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  (wait_en),
    .clr_i (wait_clr),
    .cnt_o (wait_cnt)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  (stall_en),
    .clr_i (1'b0),
    .cnt_o (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a short memory-wait limit.
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
  logic        ifid_uses_rs2, idex_memread, branch_taken, dmem_req, dmem_ready;
  logic        pc_write, ifid_write, idex_bubble, stage_en;
  logic        ifid_flush, idex_flush, exmem_flush, mem_timeout;
  logic [15:0] stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  hazard_control_unit #(
    .CNT_W      (16),
    .WAIT_LIMIT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .idex_rd       (idex_rd),
    .idex_memread  (idex_memread),
    .branch_taken  (branch_taken),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .idex_bubble   (idex_bubble),
    .stage_en      (stage_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .exmem_flush   (exmem_flush),
    .stall_cycles  (stall_cycles),
    .mem_timeout   (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rd = '0;
    ifid_uses_rs2 = 1'b0; idex_memread = 1'b0; branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #2;
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_ifid_flush", 32'(ifid_flush), 1);
    chk("rst_stall", 32'(stall_cycles), 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    // INIT cycle
    chk("init_ifid_flush", 32'(ifid_flush), 1);
    chk("init_idex_flush", 32'(idex_flush), 1);
    chk("init_exmem_flush", 32'(exmem_flush), 1);
    chk("init_pc_write", 32'(pc_write), 0);
    chk("init_stage_en", 32'(stage_en), 0);
    chk("init_bubble", 32'(idex_bubble), 0);
    tick();
    chk("run_pc_write", 32'(pc_write), 1);
    chk("run_ifid_write", 32'(ifid_write), 1);
    chk("run_stage_en", 32'(stage_en), 1);
    chk("run_ifid_flush", 32'(ifid_flush), 0);
    chk("run_stall0", 32'(stall_cycles), 0);

    // LDUR X5 then ADD X6,X5,X7
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_rs2 = 5'd7; ifid_uses_rs2 = 1'b1;
    #1;
    chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_ifid_write", 32'(ifid_write), 0);
    chk("lu_bubble", 32'(idex_bubble), 1);
    chk("lu_stage_en", 32'(stage_en), 1);
    tick();
    idex_memread = 1'b0;
    #1;
    chk("lu_stall1", 32'(stall_cycles), 1);
    chk("lu_release_pc", 32'(pc_write), 1);
    chk("lu_release_bubble", 32'(idex_bubble), 0);

    // XZR destination is never a hazard
    idex_memread = 1'b1; idex_rd = 5'd31; ifid_rs1 = 5'd31;
    #1;
    chk("xzr_pc_write", 32'(pc_write), 1);
    chk("xzr_bubble", 32'(idex_bubble), 0);

    // rs2 match only counts when rs2 is used
    idex_rd = 5'd5; ifid_rs1 = 5'd1; ifid_rs2 = 5'd5; ifid_uses_rs2 = 1'b0;
    #1;
    chk("rs2_unused_pc", 32'(pc_write), 1);
    ifid_uses_rs2 = 1'b1;
    #1;
    chk("rs2_used_pc", 32'(pc_write), 0);
    chk("rs2_used_bubble", 32'(idex_bubble), 1);
    tick();
    idex_memread = 1'b0;
    #1;
    chk("rs2_stall2", 32'(stall_cycles), 2);

    // Branch overrides load-use
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; branch_taken = 1'b1;
    #1;
    chk("br_ifid_flush", 32'(ifid_flush), 1);
    chk("br_idex_flush", 32'(idex_flush), 1);
    chk("br_exmem_flush", 32'(exmem_flush), 1);
    chk("br_pc_write", 32'(pc_write), 1);
    chk("br_bubble", 32'(idex_bubble), 0);
    tick();
    chk("br_stall_same", 32'(stall_cycles), 2);
    idex_memread = 1'b0;

    // Memory not ready for 3 cycles with a branch pending
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("mw_c1_pc", 32'(pc_write), 0);
    chk("mw_c1_stage_en", 32'(stage_en), 0);
    chk("mw_c1_flush", 32'(ifid_flush), 0);
    tick();
    chk("mw_c2_pc", 32'(pc_write), 0);
    tick();
    chk("mw_c3_pc", 32'(pc_write), 0);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("mw_c4_pc", 32'(pc_write), 0);
    chk("mw_c4_exmem_flush", 32'(exmem_flush), 0);
    chk("mw_c4_timeout", 32'(mem_timeout), 0);
    tick();
    chk("mw_run_ifid_flush", 32'(ifid_flush), 1);
    chk("mw_run_pc", 32'(pc_write), 1);
    chk("mw_stall6", 32'(stall_cycles), 6);
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    tick();

    // Ten not-ready cycles against a limit of 4
    dmem_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("to_cycle%0d", i), 32'(mem_timeout), (i >= 4) ? 1 : 0);
      chk($sformatf("to_pc%0d", i), 32'(pc_write), 0);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("to_ready_pc", 32'(pc_write), 0);
    tick();
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_run_pc", 32'(pc_write), 1);
    chk("to_stall17", 32'(stall_cycles), 17);

    // Reset in the middle of a wait
    dmem_ready = 1'b0;
    tick(); tick();
    chk("mid_wait_pc", 32'(pc_write), 0);
    reset = 1'b1;
    #1;
    chk("rst_mid_timeout", 32'(mem_timeout), 0);
    chk("rst_mid_flush", 32'(ifid_flush), 1);
    chk("rst_mid_stall", 32'(stall_cycles), 0);
    dmem_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_pc", 32'(pc_write), 1);
    chk("post_rst_timeout", 32'(mem_timeout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
